// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, requester IDs and the
// wait-counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    REQ_IF,
    REQ_D,
    REQ_DBG
  } req_id_e;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// Memory wait-state counter: loaded at grant, counts down while the access is
// in progress, reports when the final access cycle has been reached.
module mem_arb_wait_cnt
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] value,
  input  logic                  dec,
  output logic                  zero
);

  logic [WAIT_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= value;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) single-port memory arbiter with fetch starvation
// guard. Define MEM_ARB_DEBUG_PORT_EN to add a lowest-priority debug port.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
`ifdef MEM_ARB_DEBUG_PORT_EN
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT  = WAIT_CNT_W'(WAIT_STATES);

  state_e              r_state;
  req_id_e             r_winner;
  logic [STARVE_W-1:0] r_starve;
  logic                r_mem_en, r_mem_we, r_if_ack, r_d_ack;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata, r_if_rdata, r_d_rdata;

  req_id_e w_winner;
  logic    w_dbg_req, w_any_req, w_load, w_dec, w_zero;

`ifdef MEM_ARB_DEBUG_PORT_EN
  logic              r_dbg_ack;
  logic [DATA_W-1:0] r_dbg_rdata;
  assign w_dbg_req = dbg_req;
`else
  assign w_dbg_req = 1'b0;
`endif

  // Data beats fetch unless fetch has been passed over STARVE_LIMIT times.
  always_comb begin
    w_winner  = REQ_IF;
    w_any_req = if_req | d_req | w_dbg_req;
    if (d_req && !(if_req && (r_starve == STARVE_MAX))) begin
      w_winner = REQ_D;
    end else if (if_req) begin
      w_winner = REQ_IF;
    end else if (w_dbg_req) begin
      w_winner = REQ_DBG;
    end
  end

  assign w_load = (r_state == IDLE) && w_any_req;
  assign w_dec  = (r_state == ACCESS);

  mem_arb_wait_cnt u_wait_cnt (
    .clk   (CLK),
    .rst_n (Reset),
    .load  (w_load),
    .value (WAIT_INIT),
    .dec   (w_dec),
    .zero  (w_zero)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state     <= IDLE;
      r_winner    <= REQ_IF;
      r_starve    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
`ifdef MEM_ARB_DEBUG_PORT_EN
      r_dbg_ack   <= 1'b0;
      r_dbg_rdata <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (!if_req) r_starve <= '0;
          if (w_any_req) begin
            r_state  <= ACCESS;
            r_winner <= w_winner;
            r_mem_en <= 1'b1;
            case (w_winner)
              REQ_D: begin
                r_mem_addr  <= d_addr;
                r_mem_we    <= d_we;
                r_mem_wdata <= d_wdata;
              end
`ifdef MEM_ARB_DEBUG_PORT_EN
              REQ_DBG: begin
                r_mem_addr  <= dbg_addr;
                r_mem_we    <= dbg_we;
                r_mem_wdata <= dbg_wdata;
              end
`endif
              default: begin
                r_mem_addr  <= if_addr;
                r_mem_we    <= 1'b0;
                r_mem_wdata <= '0;
              end
            endcase
            if (w_winner == REQ_IF) begin
              r_starve <= '0;
            end else if ((w_winner == REQ_D) && if_req) begin
              r_starve <= r_starve + 1'b1;
            end
          end
        end
        ACCESS: begin
          // Final access cycle: sample memory, release the bus, raise the ack.
          if (w_zero) begin
            r_state  <= RESP;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_winner)
              REQ_IF: begin
                r_if_rdata <= mem_rdata;
                r_if_ack   <= 1'b1;
              end
              REQ_D: begin
                if (!r_mem_we) r_d_rdata <= mem_rdata;
                r_d_ack <= 1'b1;
              end
`ifdef MEM_ARB_DEBUG_PORT_EN
              REQ_DBG: begin
                if (!r_mem_we) r_dbg_rdata <= mem_rdata;
                r_dbg_ack <= 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end
        default: begin
          r_state  <= IDLE;
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
`ifdef MEM_ARB_DEBUG_PORT_EN
          r_dbg_ack <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_ack    = r_if_ack;
  assign if_rdata  = r_if_rdata;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != IDLE);
`ifdef MEM_ARB_DEBUG_PORT_EN
  assign dbg_ack   = r_dbg_ack;
  assign dbg_rdata = r_dbg_rdata;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, a transaction table and a
// randomized run against a latency/priority reference model.
module tb_mem_port_arbiter;

  localparam int WS = 1;
  localparam int SL = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        if_req, d_req, d_we, if_ack, d_ack;
  logic [15:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_DEBUG_PORT_EN
  logic        dbg_req, dbg_we, dbg_ack;
  logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
`endif

  logic        z_if_req, z_d_req, z_d_we, z_if_ack, z_d_ack, z_mem_en, z_mem_we, z_busy;
  logic [15:0] z_if_addr, z_d_addr, z_d_wdata, z_if_rdata, z_d_rdata;
  logic [15:0] z_mem_addr, z_mem_wdata, z_mem_rdata;

  logic        ovr_en;
  logic [15:0] ovr_val;
  logic [15:0] mem_arr [256];
  bit   [255:0] mem_wr;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  function automatic logic [15:0] pat(input logic [7:0] a);
    return {a, ~a};
  endfunction

  always @(posedge CLK) begin
    if (mem_en && mem_we) begin
      mem_arr[mem_addr[7:0]] <= mem_wdata;
      mem_wr[mem_addr[7:0]]  <= 1'b1;
    end
  end

  assign mem_rdata   = ovr_en ? ovr_val :
                       (mem_wr[mem_addr[7:0]] ? mem_arr[mem_addr[7:0]] : pat(mem_addr[7:0]));
  assign z_mem_rdata = pat(z_mem_addr[7:0]);

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(WS), .STARVE_LIMIT(SL)) u_dut (
    .CLK(CLK), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
`ifdef MEM_ARB_DEBUG_PORT_EN
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(0), .STARVE_LIMIT(SL)) u_dut_ws0 (
    .CLK(CLK), .Reset(Reset),
    .if_req(z_if_req), .if_addr(z_if_addr), .if_ack(z_if_ack), .if_rdata(z_if_rdata),
    .d_req(z_d_req), .d_we(z_d_we), .d_addr(z_d_addr), .d_wdata(z_d_wdata),
    .d_ack(z_d_ack), .d_rdata(z_d_rdata),
`ifdef MEM_ARB_DEBUG_PORT_EN
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(16'h0), .dbg_wdata(16'h0),
    .dbg_ack(), .dbg_rdata(),
`endif
    .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_rdata(z_mem_rdata), .busy(z_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, want);
    end
  endtask

  // One isolated transaction on the WS=1 DUT; checks latency, bus and result.
  task automatic run_txn(input bit fetch, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_rd, input string nm);
    int lat;
    bit other;
    logic cen, cwe;
    logic [15:0] ca, cwd;
    lat = 0; other = 0; cen = 0; cwe = 0; ca = '0; cwd = '0;
    @(negedge CLK);
    if (fetch) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge CLK);
      if (c == 1) begin cen = mem_en; cwe = mem_we; ca = mem_addr; cwd = mem_wdata; end
      if (fetch ? if_ack : d_ack) lat = c;
      if (fetch ? d_ack : if_ack) other = 1;
    end
    if_req = 1'b0; d_req = 1'b0;
    chk({nm, "_lat"}, lat, WS + 2);
    chk({nm, "_en"}, cen, 1);
    chk({nm, "_we"}, cwe, (!fetch && we) ? 1 : 0);
    chk({nm, "_addr"}, ca, addr);
    if (!fetch && we) chk({nm, "_wdata"}, cwd, wdata);
    chk({nm, "_rdata"}, fetch ? if_rdata : d_rdata, exp_rd);
    chk({nm, "_other_ack"}, other, 0);
    @(negedge CLK);
    chk({nm, "_idle"}, busy, 0);
  endtask

  typedef struct {
    bit          fetch;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs [8];

  // Random-phase reference model
  logic [15:0] model_mem [256];
  int          m_cnt, m_starve, m_kind;
  logic        m_we;
  logic [15:0] m_addr, m_wd, exp_if, exp_d;

  initial begin
    int dl, il, gl, g, lat;
    bit coin, got, prev_en;
    bit kinds [5];
    bit exp_en, exp_ack;

    vecs[0] = '{1'b1, 1'b0, 16'h0021, 16'h0000, 16'h21DE};
    vecs[1] = '{1'b0, 1'b0, 16'h0034, 16'h0000, 16'h34CB};
    vecs[2] = '{1'b0, 1'b1, 16'h0034, 16'h5A5A, 16'h34CB};
    vecs[3] = '{1'b0, 1'b0, 16'h0034, 16'h0000, 16'h5A5A};
    vecs[4] = '{1'b1, 1'b0, 16'h0034, 16'h0000, 16'h5A5A};
    vecs[5] = '{1'b0, 1'b1, 16'h00FF, 16'h0001, 16'h5A5A};
    vecs[6] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h0001};
    vecs[7] = '{1'b0, 1'b0, 16'h1200, 16'h0000, 16'h00FF};

    Reset = 1'b1; ovr_en = 1'b0; ovr_val = '0;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    z_if_req = 0; z_if_addr = '0; z_d_req = 0; z_d_we = 0; z_d_addr = '0; z_d_wdata = '0;
`ifdef MEM_ARB_DEBUG_PORT_EN
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
`endif

    // Reset state
    #2 Reset = 1'b0;
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {if_ack, d_ack}, 0);
    repeat (2) @(negedge CLK);
    chk("rst_hold_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    Reset = 1'b1;

    // Single fetch with WS=1 and fixed memory data
    @(negedge CLK);
    ovr_en = 1'b1; ovr_val = 16'hBEEF;
    if_req = 1'b1; if_addr = 16'h0010;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      chk($sformatf("fetch1_en_c%0d", c), mem_en, (c == 1 || c == 2) ? 1 : 0);
      chk($sformatf("fetch1_ack_c%0d", c), if_ack, (c == 3) ? 1 : 0);
      if (c == 1) chk("fetch1_addr", mem_addr, 16'h0010);
      if (c >= 3) chk($sformatf("fetch1_rdata_c%0d", c), if_rdata, 16'hBEEF);
      if (c == 3) if_req = 1'b0;
    end
    ovr_en = 1'b0;

    for (int i = 0; i < 8; i++)
      run_txn(vecs[i].fetch, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
              $sformatf("vec%0d", i));

    // Simultaneous store and fetch: store first, acks never overlap
    @(negedge CLK);
    if_req = 1; if_addr = 16'h0040;
    d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
    dl = 0; il = 0; coin = 0;
    for (int c = 1; c <= 20 && (dl == 0 || il == 0); c++) begin
      @(negedge CLK);
      if (c == 1) begin
        chk("prio_store_we", mem_we, 1);
        chk("prio_store_addr", mem_addr, 16'h0200);
        chk("prio_store_wdata", mem_wdata, 16'h1234);
      end
      if (c == 5) begin
        chk("prio_fetch_addr", mem_addr, 16'h0040);
        chk("prio_fetch_we", mem_we, 0);
      end
      if (if_ack && d_ack) coin = 1;
      if (d_ack) begin dl = c; d_req = 0; end
      if (if_ack) begin il = c; if_req = 0; chk("prio_fetch_rdata", if_rdata, 16'h40BF); end
    end
    chk("prio_d_ack_cycle", dl, 3);
    chk("prio_if_ack_cycle", il, 7);
    chk("prio_ack_overlap", coin, 0);
    @(negedge CLK);
    run_txn(1'b0, 1'b0, 16'h0200, 16'h0000, 16'h1234, "store_readback");

    // Starvation: continuous data traffic, fetch gets the 5th grant
    @(negedge CLK);
    if_req = 1; if_addr = 16'h0050;
    d_req = 1; d_we = 0; d_addr = 16'h0300;
    g = 0; prev_en = 0;
    for (int c = 1; c <= 60 && g < 5; c++) begin
      @(negedge CLK);
      if (mem_en && !prev_en) begin kinds[g] = (mem_addr == 16'h0050); g++; end
      prev_en = mem_en;
    end
    d_req = 0;
    chk("starve_grants", g, 5);
    for (int i = 0; i < 4; i++) chk($sformatf("starve_grant%0d_data", i), kinds[i], 0);
    chk("starve_grant4_fetch", kinds[4], 1);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge CLK);
      if (if_ack) begin got = 1; if_req = 0; chk("starve_if_rdata", if_rdata, 16'h50AF); end
    end
    chk("starve_if_ack_seen", got, 1);
    repeat (2) @(negedge CLK);
    chk("starve_idle", busy, 0);

    // Requester withdraws mid-access: ack still comes
    @(negedge CLK);
    d_req = 1; d_we = 0; d_addr = 16'h0071;
    @(negedge CLK);
    chk("drop_en", mem_en, 1);
    d_req = 0;
    lat = 0;
    for (int c = 2; c <= 10 && lat == 0; c++) begin
      @(negedge CLK);
      if (d_ack) lat = c;
    end
    chk("drop_ack_cycle", lat, 3);
    chk("drop_rdata", d_rdata, 16'h718E);

    // WS=0 back-to-back loads
    @(negedge CLK);
    z_d_req = 1; z_d_we = 0; z_d_addr = 16'h0005;
    g = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge CLK);
      chk($sformatf("b2b_en_c%0d", c), z_mem_en, (c % 3 == 1) ? 1 : 0);
      chk($sformatf("b2b_busy_c%0d", c), z_busy, (c % 3 != 0) ? 1 : 0);
      chk($sformatf("b2b_ack_c%0d", c), z_d_ack, (c % 3 == 2) ? 1 : 0);
      chk($sformatf("b2b_if_ack_c%0d", c), z_if_ack, 0);
      chk($sformatf("b2b_we_c%0d", c), z_mem_we, 0);
      if (c % 3 == 2) begin
        chk($sformatf("b2b_rdata%0d", g), z_d_rdata, pat(8'(5 + g)));
        g++;
        z_d_addr = 16'(5 + g);
      end
      if (c == 9) z_d_req = 0;
    end
    repeat (3) @(negedge CLK);
    chk("b2b_idle", z_busy, 0);
    chk("b2b_if_rdata", z_if_rdata, 0);
    chk("b2b_wdata", z_mem_wdata, 0);

`ifdef MEM_ARB_DEBUG_PORT_EN
    // Debug port yields to fetch
    @(negedge CLK);
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0090;
    if_req = 1; if_addr = 16'h0091;
    il = 0; gl = 0; coin = 0;
    for (int c = 1; c <= 20 && (il == 0 || gl == 0); c++) begin
      @(negedge CLK);
      if (c == 1) chk("dbg_first_addr", mem_addr, 16'h0091);
      if (if_ack && dbg_ack) coin = 1;
      if (if_ack) begin il = c; if_req = 0; end
      if (dbg_ack) begin gl = c; dbg_req = 0; chk("dbg_rdata", dbg_rdata, 16'h906F); end
    end
    chk("dbg_if_cycle", il, 3);
    chk("dbg_ack_cycle", gl, 7);
    chk("dbg_overlap", coin, 0);
    @(negedge CLK);
`endif

    // Reset during ACCESS aborts without ack
    @(negedge CLK);
    if_req = 1; if_addr = 16'h0060;
    @(negedge CLK);
    chk("rstmid_pre_en", mem_en, 1);
    #2 Reset = 1'b0;
    #1;
    chk("rstmid_en", mem_en, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_addr", mem_addr, 0);
    chk("rstmid_rdata", {if_rdata, d_rdata}, 0);
    if_req = 0;
    got = 0;
    repeat (3) begin
      @(negedge CLK);
      if (if_ack || d_ack) got = 1;
    end
    chk("rstmid_no_ack", got, 0);
    Reset = 1'b1;
    run_txn(1'b1, 1'b0, 16'h0061, 16'h0000, 16'h619E, "post_rst");

    // Randomized traffic against the reference model
    @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = mem_wr[i] ? mem_arr[i] : pat(8'(i));
    m_cnt = 0; m_starve = 0; m_kind = 0; m_we = 0; m_addr = '0; m_wd = '0;
    exp_if = '0; exp_d = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge CLK);
      if (m_cnt == 0) begin
        if (!if_req) m_starve = 0;
        if (if_req || d_req) begin
          if (if_req && (m_starve == SL || !d_req)) begin
            m_kind = 0; m_addr = if_addr; m_we = 0; m_starve = 0;
          end else begin
            m_kind = 1; m_addr = d_addr; m_we = d_we; m_wd = d_wdata;
            if (if_req) m_starve++;
          end
          m_cnt = WS + 2;
        end
      end else begin
        m_cnt--;
      end
      exp_en  = (m_cnt >= 2);
      exp_ack = (m_cnt == 1);
      if (exp_ack) begin
        if (m_kind == 0) exp_if = model_mem[m_addr[7:0]];
        else if (!m_we) exp_d = model_mem[m_addr[7:0]];
        else model_mem[m_addr[7:0]] = m_wd;
      end
      chk("rnd_busy", busy, (m_cnt != 0) ? 1 : 0);
      chk("rnd_mem_en", mem_en, exp_en);
      chk("rnd_mem_we", mem_we, (exp_en && m_we) ? 1 : 0);
      chk("rnd_if_ack", if_ack, (exp_ack && m_kind == 0) ? 1 : 0);
      chk("rnd_d_ack", d_ack, (exp_ack && m_kind == 1) ? 1 : 0);
      chk("rnd_if_rdata", if_rdata, exp_if);
      chk("rnd_d_rdata", d_rdata, exp_d);
      if (exp_en) begin
        chk("rnd_mem_addr", mem_addr, m_addr);
        if (m_we) chk("rnd_mem_wdata", mem_wdata, m_wd);
      end
      if (exp_ack && m_kind == 0) if_req = 0;
      if (exp_ack && m_kind == 1) d_req = 0;
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1; if_addr = {8'($urandom), 8'($urandom_range(128, 239))};
      end
      if (!d_req && $urandom_range(0, 3) != 0) begin
        d_req = 1; d_we = 1'($urandom);
        d_addr = {8'($urandom), 8'($urandom_range(128, 239))};
        d_wdata = 16'($urandom);
      end
    end
    if_req = 0; d_req = 0;
    repeat (6) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
